// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU store path: drain FSM encoding and store-buffer defaults.
package cpu_pkg;

    // Drain FSM state encoding.
    typedef logic [0:0] sb_state_t;
    localparam sb_state_t SB_IDLE = 1'b0;
    localparam sb_state_t SB_REQ  = 1'b1;

    // Default number of buffered stores.
    localparam int unsigned SB_DEPTH = 4;

    // Byte-offset bits within a 32-bit word; cleared to align, tested for misalignment.
    localparam logic [1:0] SB_OFFSET_MASK = 2'b11;

endpackage

// File: rtl/store_fifo.sv
// DEPTH-entry FIFO holding {aligned address, data} store entries with an occupancy count.
module store_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointer and occupancy next-state; pointers wrap modulo DEPTH by width.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the CPU store path and a slow data memory; queues stores and drains
// them one at a time over a req/ack handshake.
module store_buffer
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wmem,
    input  logic [AW-1:0]          aluout,
    input  logic [DW-1:0]          data,
    output logic                   stall,
    output logic                   mem_req,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    input  logic                   mem_ack,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   empty,
    output logic                   misalign
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              push;
    logic              pop;
    logic [AW+DW-1:0]  fifo_wdata;
    logic [AW+DW-1:0]  fifo_rdata;
    logic [CW-1:0]     count;

    sb_state_t         state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic              misalign_q, misalign_d;

    // Full buffer stalls even if a pop lands this cycle; no same-cycle bypass.
    assign stall      = wmem & (count == CW'(DEPTH));
    assign push       = wmem & ~stall;
    assign pop        = (state_q == SB_REQ) & mem_ack;
    assign fifo_wdata = {aluout[AW-1:2], aluout[1:0] & ~SB_OFFSET_MASK, data};

    store_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (count)
    );

    // Drain FSM: latch the head entry, hold the request until acked, then idle one cycle.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            SB_IDLE: begin
                if (count != '0) begin
                    mem_addr_d  = fifo_rdata[AW+DW-1:DW];
                    mem_wdata_d = fifo_rdata[DW-1:0];
                    mem_req_d   = 1'b1;
                    state_d     = SB_REQ;
                end
            end
            SB_REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = SB_IDLE;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = SB_IDLE;
            end
        endcase
    end

    // Sticky misalignment flag, set only by accepted stores.
    always_comb begin
        misalign_d = misalign_q | (push & (|(aluout[1:0] & SB_OFFSET_MASK)));
    end

    // Drain and flag registers; reset drops the request asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= SB_IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            misalign_q  <= misalign_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pending   = count;
    assign empty     = (count == '0);
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue-based reference model tracks accepted stores and
// the expected request timing; a negedge monitor compares every DUT output against it.
module tb_store_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } st_t;

    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic        wmem    = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] aluout  = '0;
    logic [31:0] data    = '0;

    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  pending;
    logic        empty;
    logic        misalign;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    st_t  mq[$];
    st_t  sb[$];
    st_t  m_head = '0;
    st_t  ne;
    st_t  se;
    logic m_req  = 1'b0;
    logic m_mis  = 1'b0;
    logic m_acc  = 1'b0;
    logic acc;
    logic hs;

    store_buffer #(
        .DEPTH (DEPTH),
        .AW    (32),
        .DW    (32)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .wmem      (wmem),
        .aluout    (aluout),
        .data      (data),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .pending   (pending),
        .empty     (empty),
        .misalign  (misalign)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of stores; a request starts the edge after an idle cycle with work queued
    // and ends on the edge it is acked.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
            sb.delete();
            m_req  = 1'b0;
            m_head = '0;
            m_mis  = 1'b0;
            m_acc  = 1'b0;
        end else begin
            acc = wmem && (mq.size() < DEPTH);
            hs  = m_req && mem_ack;
            if (m_req) begin
                if (mem_ack) m_req = 1'b0;
            end else if (mq.size() > 0) begin
                m_req  = 1'b1;
                m_head = mq[0];
            end
            if (hs) void'(mq.pop_front());
            if (acc) begin
                ne.a = {aluout[31:2], 2'b00};
                ne.d = data;
                mq.push_back(ne);
                sb.push_back(ne);
                if (aluout[1:0] != 2'b00) m_mis = 1'b1;
            end
            m_acc = acc;
        end
    end

    // Monitor: compare status each cycle; pop the scoreboard on every completed handshake.
    always @(negedge clock) begin
        chk("pending", 64'(pending), 64'(mq.size()));
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        chk("stall", 64'(stall), 64'(wmem && (mq.size() == DEPTH)));
        chk("misalign", 64'(misalign), 64'(m_mis));
        chk("mem_req", 64'(mem_req), 64'(m_req));
        if (mem_req && m_req) begin
            chk("req_addr", 64'(mem_addr), 64'(m_head.a));
            chk("req_data", 64'(mem_wdata), 64'(m_head.d));
        end
        if (reset && mem_req && mem_ack) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got write %0h expected none", mem_addr);
            end else begin
                se = sb.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(se.a));
                chk("wr_data", 64'(mem_wdata), 64'(se.d));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one store and hold it until accepted (bounded).
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        int n;
        n      = 0;
        wmem   = 1'b1;
        aluout = a;
        data   = d;
        step();
        while (!m_acc && n < 50) begin
            step();
            n++;
        end
        if (!m_acc) begin
            total++;
            bad++;
            $display("FAIL store_timeout: got no accept expected accept for %0h", a);
        end
        wmem = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        #1 reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_misalign", 64'(misalign), 64'd0);

        // Single store
        mem_ack = 1'b1;
        store(32'h0000_0010, 32'hDEAD_BEEF);
        chk("t2_req_n", 64'(mem_req), 64'd0);
        step();
        chk("t2_req_n1", 64'(mem_req), 64'd1);
        chk("t2_addr", 64'(mem_addr), 64'h10);
        chk("t2_data", 64'(mem_wdata), 64'hDEAD_BEEF);
        step();
        chk("t2_req_n2", 64'(mem_req), 64'd0);
        chk("t2_pending", 64'(pending), 64'd0);

        // Fill and stall
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) store(32'(i * 4), $urandom);
        chk("t3_full", 64'(pending), 64'd4);
        wmem   = 1'b1;
        aluout = 32'h10;
        data   = 32'hCAFE_0010;
        #1;
        chk("t3_stall", 64'(stall), 64'd1);
        step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        chk("t3_fifth_acc", 64'(m_acc), 64'd1);
        chk("t3_pending", 64'(pending), 64'd4);
        wmem    = 1'b0;
        mem_ack = 1'b1;
        repeat (12) step();
        mem_ack = 1'b0;

        // Simultaneous push and pop
        store(32'h100, 32'hAAAA_0001);
        store(32'h104, 32'hAAAA_0002);
        chk("t4_req", 64'(mem_req), 64'd1);
        chk("t4_pending_before", 64'(pending), 64'd2);
        wmem    = 1'b1;
        aluout  = 32'h108;
        data    = 32'hAAAA_0003;
        mem_ack = 1'b1;
        step();
        wmem    = 1'b0;
        mem_ack = 1'b0;
        chk("t4_pending_after", 64'(pending), 64'd2);
        mem_ack = 1'b1;
        repeat (10) step();

        // Misalign
        store(32'h0000_0023, 32'h1234_5678);
        chk("t5_misalign", 64'(misalign), 64'd1);
        step();
        chk("t5_req", 64'(mem_req), 64'd1);
        chk("t5_addr", 64'(mem_addr), 64'h20);
        repeat (4) step();
        chk("t5_sticky", 64'(misalign), 64'd1);

        // Randomized traffic, holding a stalled store stable
        for (int i = 0; i < 400; i++) begin
            if (!wmem || m_acc) begin
                wmem   = 1'($urandom_range(0, 1));
                aluout = $urandom;
                data   = $urandom;
            end
            mem_ack = 1'($urandom_range(0, 1));
            step();
        end
        wmem    = 1'b0;
        mem_ack = 1'b1;
        repeat (12) step();

        // Reset mid-transaction
        mem_ack = 1'b0;
        store(32'h200, 32'hBBBB_0001);
        store(32'h204, 32'hBBBB_0002);
        store(32'h208, 32'hBBBB_0003);
        chk("t6_req", 64'(mem_req), 64'd1);
        chk("t6_pending", 64'(pending), 64'd3);
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        chk("t6_req_drop", 64'(mem_req), 64'd0);
        chk("t6_pending_clr", 64'(pending), 64'd0);
        step();
        reset   = 1'b1;
        mem_ack = 1'b1;
        repeat (10) begin
            step();
            chk("t6_no_write", 64'(mem_req), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
